// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Single outstanding request; ready completes it in the same cycle.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, drives the shared PC adder, issues
// one-outstanding imem requests and loads the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_cin,
  input  logic [31:0]            add_sum,
  input  logic                   add_cout,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4,
  output logic [31:0]            id_instr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] skid;
  logic [31:0] tgt_pc;
  logic        unused_ok;

  assign tgt_pc    = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^{add_cout, redirect_pc[1:0]};

  assign add_a   = pc;
  assign add_b   = 32'd4;
  assign add_cin = 1'b0;

  // DROP keeps the abandoned address on the bus until imem answers it
  assign imem.req  = (state == REQ) || (state == DROP);
  assign imem.addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop_addr   <= RESET_PC;
      skid        <= NOP_INSTR;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_instr    <= NOP_INSTR;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect_valid) begin
            pc       <= tgt_pc;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            pc       <= tgt_pc;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            if (!imem.ready) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (imem.ready && !stall) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= add_sum;
            id_instr    <= imem.rdata;
            pc          <= add_sum;
          end else if (imem.ready) begin
            skid  <= imem.rdata;
            state <= HOLD;
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc       <= tgt_pc;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state    <= REQ;
          end else if (!stall) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= add_sum;
            id_instr    <= skid;
            pc          <= add_sum;
            state       <= REQ;
          end
        end
        default: begin
          if (redirect_valid) begin
            pc       <= tgt_pc;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
          if (imem.ready) state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall skid, redirect
// drop, misaligned target, PC wrap and async reset mid-state.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;

  logic        reset1, stall1, redirect_valid1;
  logic [31:0] redirect_pc1;
  logic [31:0] add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;
  logic        id_valid1;
  logic [31:0] id_pc1, id_pc_plus4_1, id_instr1;

  int checks = 0;
  int failures = 0;

  if_fetch_unit_if bus0 ();
  if_fetch_unit_if bus1 ();

  always #5 clk = ~clk;

  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {32'd0, add_cin1};

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) u0 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(bus0.master),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .reset(reset1), .stall(stall1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .imem(bus1.master),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .id_valid(id_valid1), .id_pc(id_pc1),
    .id_pc_plus4(id_pc_plus4_1), .id_instr(id_instr1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_req"},   {31'd0, bus0.req}, 32'd0);
    check({tag, "_addr"},  bus0.addr, 32'h100);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_pc"},    id_pc, 32'd0);
    check({tag, "_pc4"},   id_pc_plus4, 32'd0);
    check({tag, "_instr"}, id_instr, 32'h13);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus0.ready = 1'b0; bus0.rdata = '0;
    reset1 = 1'b1; stall1 = 1'b0; redirect_valid1 = 1'b0; redirect_pc1 = '0;
    bus1.ready = 1'b0; bus1.rdata = '0;

    @(negedge clk);
    check_rst("rst");
    check("add_a", add_a, 32'h100);
    check("add_b", add_b, 32'd4);
    check("add_cin", {31'd0, add_cin}, 32'd0);

    // release: one IDLE cycle, then request RESET_PC
    reset = 1'b0;
    #1 check("idle_req", {31'd0, bus0.req}, 32'd0);
    @(negedge clk);
    check("req_on", {31'd0, bus0.req}, 32'd1);
    check("req_addr", bus0.addr, 32'h100);
    check("req_valid", {31'd0, id_valid}, 32'd0);

    // streaming at one instruction per cycle
    bus0.ready = 1'b1; bus0.rdata = 32'hA000_0001;
    @(negedge clk);
    check("s0_pc", id_pc, 32'h100);
    check("s0_pc4", id_pc_plus4, 32'h104);
    check("s0_instr", id_instr, 32'hA000_0001);
    check("s0_valid", {31'd0, id_valid}, 32'd1);
    check("s0_addr", bus0.addr, 32'h104);
    bus0.rdata = 32'hB000_0002;
    @(negedge clk);
    check("s1_pc", id_pc, 32'h104);
    check("s1_pc4", id_pc_plus4, 32'h108);
    check("s1_instr", id_instr, 32'hB000_0002);
    bus0.rdata = 32'hC000_0003;
    @(negedge clk);
    check("s2_pc", id_pc, 32'h108);
    check("s2_pc4", id_pc_plus4, 32'h10C);
    check("s2_instr", id_instr, 32'hC000_0003);

    // stall on response -> HOLD with skid
    bus0.rdata = 32'hD000_0004; stall = 1'b1;
    @(negedge clk);
    check("hold_req", {31'd0, bus0.req}, 32'd0);
    check("hold_pc", id_pc, 32'h108);
    check("hold_instr", id_instr, 32'hC000_0003);
    bus0.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("hold2_req", {31'd0, bus0.req}, 32'd0);
    check("hold2_instr", id_instr, 32'hC000_0003);
    stall = 1'b0; bus0.ready = 1'b0;
    @(negedge clk);
    check("unhold_pc", id_pc, 32'h10C);
    check("unhold_pc4", id_pc_plus4, 32'h110);
    check("unhold_instr", id_instr, 32'hD000_0004);
    check("unhold_valid", {31'd0, id_valid}, 32'd1);
    check("unhold_req", {31'd0, bus0.req}, 32'd1);
    check("unhold_addr", bus0.addr, 32'h110);

    // no response, no stall -> bubble
    @(negedge clk);
    check("bub_valid", {31'd0, id_valid}, 32'd0);
    check("bub_pc", id_pc, 32'h10C);

    // redirect while 0x110 pending -> DROP
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drop_req", {31'd0, bus0.req}, 32'd1);
    check("drop_addr", bus0.addr, 32'h110);
    check("drop_valid", {31'd0, id_valid}, 32'd0);
    check("drop_instr", id_instr, 32'h13);
    check("drop_pc", id_pc, 32'h10C);
    @(negedge clk);
    check("drop2_addr", bus0.addr, 32'h110);
    bus0.ready = 1'b1; bus0.rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    check("dropd_addr", bus0.addr, 32'h200);
    check("dropd_valid", {31'd0, id_valid}, 32'd0);
    check("dropd_instr", id_instr, 32'h13);
    bus0.rdata = 32'hE000_0005;
    @(negedge clk);
    check("tgt_pc", id_pc, 32'h200);
    check("tgt_pc4", id_pc_plus4, 32'h204);
    check("tgt_instr", id_instr, 32'hE000_0005);
    check("tgt_addr", bus0.addr, 32'h204);

    // misaligned redirect coincident with ready: redirect wins
    redirect_valid = 1'b1; redirect_pc = 32'h303; bus0.rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis_addr", bus0.addr, 32'h300);
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    check("mis_instr", id_instr, 32'h13);
    bus0.rdata = 32'hF000_0006;
    @(negedge clk);
    check("mis_pc", id_pc, 32'h300);
    check("mis_pc4", id_pc_plus4, 32'h304);
    check("mis_inst2", id_instr, 32'hF000_0006);

    // redirect beats stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
    bus0.rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    check("rvs_req", {31'd0, bus0.req}, 32'd1);
    check("rvs_addr", bus0.addr, 32'h400);
    check("rvs_valid", {31'd0, id_valid}, 32'd0);

    // redirect out of HOLD discards skid
    stall = 1'b1; bus0.rdata = 32'h1111_0007;
    @(negedge clk);
    check("h2_req", {31'd0, bus0.req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h600; bus0.ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    check("hr_req", {31'd0, bus0.req}, 32'd1);
    check("hr_addr", bus0.addr, 32'h600);
    check("hr_valid", {31'd0, id_valid}, 32'd0);
    bus0.ready = 1'b1; bus0.rdata = 32'h2222_0008;
    @(negedge clk);
    check("hr_pc", id_pc, 32'h600);
    check("hr_instr", id_instr, 32'h2222_0008);

    // async reset in HOLD
    stall = 1'b1; bus0.rdata = 32'h3333_0009;
    @(negedge clk);
    check("h3_req", {31'd0, bus0.req}, 32'd0);
    #2 reset = 1'b1;
    #1 check_rst("arst_hold");
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; bus0.ready = 1'b0;
    #1 check("ar_idle", {31'd0, bus0.req}, 32'd0);
    @(negedge clk);
    check("ar_addr", bus0.addr, 32'h100);
    bus0.ready = 1'b1; bus0.rdata = 32'h4444_000A;
    @(negedge clk);
    check("ar_pc", id_pc, 32'h100);

    // async reset in DROP
    bus0.ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("d2_req", {31'd0, bus0.req}, 32'd1);
    check("d2_addr", bus0.addr, 32'h104);
    #2 reset = 1'b1;
    #1 check_rst("arst_drop");
    @(negedge clk);
    reset = 1'b0;

    // PC wrap instance
    reset1 = 1'b0;
    #1 check("w_idle", {31'd0, bus1.req}, 32'd0);
    check("w_raddr", bus1.addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("w_req", {31'd0, bus1.req}, 32'd1);
    check("w_addr", bus1.addr, 32'hFFFF_FFFC);
    check("w_adda", add_a1, 32'hFFFF_FFFC);
    bus1.ready = 1'b1; bus1.rdata = 32'h5555_000B;
    @(negedge clk);
    check("w_pc", id_pc1, 32'hFFFF_FFFC);
    check("w_pc4", id_pc_plus4_1, 32'd0);
    check("w_instr", id_instr1, 32'h5555_000B);
    check("w_next", bus1.addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
